postprocess_linear_ngroup: RTL

Parametrised multi-channel successor to the single-group linear post-processing accumulator. It computes N_CH output neurons of a fully-connected layer in parallel. One signed activation per beat is shared across all channels, and each channel has its own weight. Each accumulator is seeded with its bias at start. A counter tracks the dot-product length, so the block no longer relies on an external iteration index. Inputs and outputs use valid/ready handshakes, accumulation saturates, and an optional ReLU is applied on output. The block sits between the activation/weight fetch logic and the result writeback buffer.

---
 rtl/postprocess_pkg.sv | 18 +
 rtl/postprocess_mac_lane.sv | 57 +++++
 rtl/postprocess_linear_ngroup.sv | 116 +++++++++++
 3 files changed

// File: rtl/postprocess_pkg.sv
// Shared constants and types for the multi-channel linear post-processing block.
package postprocess_pkg;

  localparam int DATA_W   = 8;
  localparam int WEIGHT_W = 8;
  localparam int ACC_W    = 32;

  // Saturation bounds for the default accumulator width.
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/postprocess_mac_lane.sv
// Single output lane: bias load, saturating multiply-accumulate and ReLU view.
module postprocess_mac_lane #(
  parameter int DATA_W   = postprocess_pkg::DATA_W,
  parameter int WEIGHT_W = postprocess_pkg::WEIGHT_W,
  parameter int ACC_W    = postprocess_pkg::ACC_W
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       load,
  input  logic                       mac_en,
  input  logic                       relu_en,
  input  logic signed [ACC_W-1:0]    bias,
  input  logic signed [DATA_W-1:0]   data_in,
  input  logic signed [WEIGHT_W-1:0] weight,
  output logic signed [ACC_W-1:0]    y
);

  localparam int PW = DATA_W + WEIGHT_W;
  localparam logic signed [ACC_W-1:0] LANE_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] LANE_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] sat;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W:0]   sum;

  // Full-precision product, one-bit-wider sum, then clamp on overflow.
  always_comb begin
    prod = data_in * weight;
    sum  = {acc[ACC_W-1], acc} + {{(ACC_W+1-PW){prod[PW-1]}}, prod};
    if (sum[ACC_W] != sum[ACC_W-1])
      sat = sum[ACC_W] ? LANE_MIN : LANE_MAX;
    else
      sat = sum[ACC_W-1:0];
  end

  // Value the accumulator takes this cycle; y exposes it so the top can
  // register the result in the same cycle as the final update.
  always_comb begin
    acc_d = acc;
    if (load)
      acc_d = bias;
    else if (mac_en)
      acc_d = sat;
    y = (relu_en && acc_d[ACC_W-1]) ? '0 : acc_d;
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      acc <= '0;
    else
      acc <= acc_d;
  end

endmodule

// File: rtl/postprocess_linear_ngroup.sv
// N_CH-lane fully-connected post-processing: shared activation, per-lane weights,
// bias seeding, length counter, valid/ready on both sides, saturation and ReLU.
module postprocess_linear_ngroup #(
  parameter int N_CH     = 4,
  parameter int DATA_W   = postprocess_pkg::DATA_W,
  parameter int WEIGHT_W = postprocess_pkg::WEIGHT_W,
  parameter int ACC_W    = postprocess_pkg::ACC_W,
  parameter int LEN_W    = 9
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic                     relu_en,
  input  logic [N_CH*ACC_W-1:0]    bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [N_CH*WEIGHT_W-1:0] weight,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_CH*ACC_W-1:0]    data_out,
  output logic                     busy
);

  import postprocess_pkg::*;

  state_t                  state;
  logic [LEN_W-1:0]        cnt;
  logic [LEN_W-1:0]        len_q;
  logic                    relu_q;
  logic                    load;
  logic                    mac_en;
  logic                    relu_sel;
  logic                    last_beat;
  logic [N_CH*ACC_W-1:0]   y_all;

  // Lane control strobes; ReLU uses the live input when the bias is loaded
  // so a zero-length job outputs the correct clamped bias.
  always_comb begin
    load      = (state == IDLE) && start;
    mac_en    = (state == ACCUM) && in_valid && in_ready;
    relu_sel  = load ? relu_en : relu_q;
    last_beat = (cnt == len_q - LEN_W'(1));
  end

  assign busy = (state != IDLE);

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    postprocess_mac_lane #(
      .DATA_W   (DATA_W),
      .WEIGHT_W (WEIGHT_W),
      .ACC_W    (ACC_W)
    ) u_lane (
      .clk      (clk),
      .rst_b    (rst_b),
      .load     (load),
      .mac_en   (mac_en),
      .relu_en  (relu_sel),
      .bias     (bias[c*ACC_W +: ACC_W]),
      .data_in  (data_in),
      .weight   (weight[c*WEIGHT_W +: WEIGHT_W]),
      .y        (y_all[c*ACC_W +: ACC_W])
    );
  end

  // Control FSM with registered handshake outputs and result register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      relu_q    <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q  <= len;
            relu_q <= relu_en;
            cnt    <= '0;
            if (len == '0) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              data_out  <= y_all;
            end else begin
              state    <= ACCUM;
              in_ready <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (mac_en) begin
            cnt <= cnt + LEN_W'(1);
            if (last_beat) begin
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              data_out  <= y_all;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
